cpu_run_monitor: RTL and testbench

- Synthesisable run-control and observation block for the CPU simulation harness.
- Sits between the harness clock/reset and the `cpu` instance:
  - sequences the CPU reset;
  - counts run cycles;
  - ends the run on halt, timeout or a PC self-loop, and reports why;
  - keeps a ring-buffer trace of the most recent distinct PC values for post-mortem reads.

---
 rtl/cpu_run_monitor_pkg.sv | 17 +
 rtl/cpu_run_monitor_trace_ring.sv | 55 +++++
 rtl/cpu_run_monitor.sv | 159 +++++++++++++++
 tb/tb_cpu_run_monitor.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_monitor_pkg.sv
// Shared types for the CPU run monitor: FSM state encoding and run status codes.
package cpu_run_monitor_pkg;

   typedef enum logic [1:0] {
      StHold = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } run_state_e;

   typedef enum logic [1:0] {
      RUN_ST_RUNNING = 2'd0,
      RUN_ST_HALT    = 2'd1,
      RUN_ST_TIMEOUT = 2'd2,
      RUN_ST_LOOP    = 2'd3
   } run_status_e;

endpackage

// File: rtl/cpu_run_monitor_trace_ring.sv
// Circular trace buffer: appends on write enable, saturating entry count, and an
// oldest-relative combinational read port returning 0 past the valid entries.
module cpu_run_monitor_trace_ring #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned DATA_W = 64
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_we,
   input  logic [DATA_W-1:0]        i_wdata,
   output logic [$clog2(DEPTH):0]   o_count,
   input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
   output logic [DATA_W-1:0]        o_rd_data
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned CNTW = AW + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW:0]       r_count;
   logic              w_full;
   logic [AW-1:0]     w_oldest;
   logic [AW-1:0]     w_rd_addr;
   logic              w_rd_valid;

   assign w_full = (r_count == CNTW'(DEPTH));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (i_we) begin
         r_wr_ptr <= r_wr_ptr + 1'b1;
         if (!w_full) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   // Storage needs no reset: entries beyond r_count are masked on read.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Until the ring fills, the oldest entry sits at slot 0; afterwards at the write pointer.
   assign w_oldest   = w_full ? r_wr_ptr : '0;
   assign w_rd_addr  = w_oldest + i_rd_idx;
   assign w_rd_valid = ({1'b0, i_rd_idx} < r_count);
   assign o_rd_data  = w_rd_valid ? r_mem[w_rd_addr] : '0;
   assign o_count    = r_count;

endmodule

// File: rtl/cpu_run_monitor.sv
// CPU run control/observation: reset sequencing, cycle counting, termination and PC trace.
// Optional self-loop detection is enabled by defining CPU_RUN_MONITOR_LOOP_DET_EN.
module cpu_run_monitor
   import cpu_run_monitor_pkg::*;
#(
   parameter int unsigned PC_W           = 64,
   parameter int unsigned TRACE_DEPTH    = 16,
   parameter int unsigned RESET_CYCLES   = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int unsigned LOOP_LIMIT     = 4
) (
   input  logic                           i_clk,
   input  logic                           i_reset,
   output logic                           o_cpu_reset,
   input  logic [PC_W-1:0]                i_pc,
   input  logic                           i_halted,
   output logic                           o_run,
   output logic                           o_done,
   output logic [1:0]                     o_status,
   output logic [31:0]                    o_cycle_count,
   output logic [$clog2(TRACE_DEPTH):0]   o_trace_count,
   input  logic [$clog2(TRACE_DEPTH)-1:0] i_trace_rd_idx,
   output logic [PC_W-1:0]                o_trace_rd_pc
);

   localparam int unsigned HOLD_W = $clog2(RESET_CYCLES + 1);

   if (TRACE_DEPTH < 2 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("TRACE_DEPTH must be a power of two and at least 2");
   end
   if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
      $error("RESET_CYCLES must be at least 1");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end
   if (LOOP_LIMIT < 1) begin : g_bad_loop_limit
      $error("LOOP_LIMIT must be at least 1");
   end

   run_state_e        r_state;
   run_state_e        w_state_nxt;
   run_status_e       r_status;
   run_status_e       w_status_nxt;
   logic [HOLD_W-1:0] r_hold_cnt;
   logic [HOLD_W-1:0] w_hold_nxt;
   logic [31:0]       r_cycle_count;
   logic [31:0]       w_cycle_nxt;
   logic [31:0]       w_cycle_inc;
   logic [PC_W-1:0]   r_last_pc;
   logic [PC_W-1:0]   w_last_pc_nxt;
   logic              w_first;
   logic              w_pc_same;
   logic              w_trace_we;

`ifdef CPU_RUN_MONITOR_LOOP_DET_EN
   localparam int unsigned LOOP_W = $clog2(LOOP_LIMIT + 1);
   logic [LOOP_W-1:0] r_loop_cnt;
   logic [LOOP_W-1:0] w_loop_nxt;
`endif

   // cycle_count is zero only before the first RUN edge, so it doubles as the first-edge flag.
   assign w_first     = (r_cycle_count == '0);
   assign w_pc_same   = (i_pc == r_last_pc);
   assign w_cycle_inc = r_cycle_count + 32'd1;

   always_comb begin
      w_state_nxt   = r_state;
      w_status_nxt  = r_status;
      w_hold_nxt    = r_hold_cnt;
      w_cycle_nxt   = r_cycle_count;
      w_last_pc_nxt = r_last_pc;
      w_trace_we    = 1'b0;
`ifdef CPU_RUN_MONITOR_LOOP_DET_EN
      w_loop_nxt    = r_loop_cnt;
`endif
      unique case (r_state)
         StHold: begin
            if (r_hold_cnt == HOLD_W'(RESET_CYCLES - 1)) begin
               w_state_nxt = StRun;
               w_hold_nxt  = '0;
            end else begin
               w_hold_nxt = r_hold_cnt + 1'b1;
            end
         end
         StRun: begin
            w_cycle_nxt   = w_cycle_inc;
            w_last_pc_nxt = i_pc;
            w_trace_we    = w_first || !w_pc_same;
`ifdef CPU_RUN_MONITOR_LOOP_DET_EN
            w_loop_nxt    = (w_first || !w_pc_same) ? '0 : r_loop_cnt + 1'b1;
`endif
            if (i_halted) begin
               w_state_nxt  = StDone;
               w_status_nxt = RUN_ST_HALT;
            end
`ifdef CPU_RUN_MONITOR_LOOP_DET_EN
            else if (w_loop_nxt == LOOP_W'(LOOP_LIMIT)) begin
               w_state_nxt  = StDone;
               w_status_nxt = RUN_ST_LOOP;
            end
`endif
            else if (w_cycle_inc == 32'(TIMEOUT_CYCLES)) begin
               w_state_nxt  = StDone;
               w_status_nxt = RUN_ST_TIMEOUT;
            end
         end
         StDone: begin
         end
         default: w_state_nxt = StHold;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state       <= StHold;
         r_status      <= RUN_ST_RUNNING;
         r_hold_cnt    <= '0;
         r_cycle_count <= '0;
         r_last_pc     <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_status      <= w_status_nxt;
         r_hold_cnt    <= w_hold_nxt;
         r_cycle_count <= w_cycle_nxt;
         r_last_pc     <= w_last_pc_nxt;
      end
   end

`ifdef CPU_RUN_MONITOR_LOOP_DET_EN
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_loop_cnt <= '0;
      end else begin
         r_loop_cnt <= w_loop_nxt;
      end
   end
`endif

   cpu_run_monitor_trace_ring #(
      .DEPTH  (TRACE_DEPTH),
      .DATA_W (PC_W)
   ) u_trace_ring (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_we      (w_trace_we),
      .i_wdata   (i_pc),
      .o_count   (o_trace_count),
      .i_rd_idx  (i_trace_rd_idx),
      .o_rd_data (o_trace_rd_pc)
   );

   assign o_cpu_reset   = (r_state == StHold);
   assign o_run         = (r_state == StRun);
   assign o_done        = (r_state == StDone);
   assign o_status      = r_status;
   assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed self-checking bench for cpu_run_monitor (PC_W=64, depth 16, timeout 20, loop limit 4).
module tb_cpu_run_monitor;

   logic        clk;
   logic        rst;
   logic        cpu_reset;
   logic [63:0] pc;
   logic        halted;
   logic        run;
   logic        done;
   logic [1:0]  status;
   logic [31:0] cycle_count;
   logic [4:0]  trace_count;
   logic [3:0]  rd_idx;
   logic [63:0] rd_pc;

   int total = 0;
   int bad   = 0;

   cpu_run_monitor #(
      .PC_W           (64),
      .TRACE_DEPTH    (16),
      .RESET_CYCLES   (2),
      .TIMEOUT_CYCLES (20),
      .LOOP_LIMIT     (4)
   ) dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .o_cpu_reset    (cpu_reset),
      .i_pc           (pc),
      .i_halted       (halted),
      .o_run          (run),
      .o_done         (done),
      .o_status       (status),
      .o_cycle_count  (cycle_count),
      .o_trace_count  (trace_count),
      .i_trace_rd_idx (rd_idx),
      .o_trace_rd_pc  (rd_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reset, release on a falling edge, then wait out the two HOLD edges; returns in RUN.
   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; pc = '0; halted = 1'b0; rd_idx = '0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1;
      total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL reset_cpu_reset got=%0b want=1", cpu_reset); end
      total++; if (run !== 1'b0) begin bad++; $display("FAIL reset_run got=%0b want=0", run); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
      total++; if (status !== 2'd0) begin bad++; $display("FAIL reset_status got=%0d want=0", status); end
      total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL reset_cycles got=%0d want=0", cycle_count); end
      total++; if (trace_count !== 5'd0) begin bad++; $display("FAIL reset_trace_count got=%0d want=0", trace_count); end
      total++; if (rd_pc !== 64'd0) begin bad++; $display("FAIL reset_rd_pc got=%h want=0", rd_pc); end
      #9 rst = 1'b0;
      @(posedge clk); #1;
      total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL hold_edge1_cpu_reset got=%0b want=1", cpu_reset); end
      total++; if (run !== 1'b0) begin bad++; $display("FAIL hold_edge1_run got=%0b want=0", run); end
      @(posedge clk); #1;
      total++; if (cpu_reset !== 1'b0) begin bad++; $display("FAIL hold_edge2_cpu_reset got=%0b want=0", cpu_reset); end
      total++; if (run !== 1'b1) begin bad++; $display("FAIL hold_edge2_run got=%0b want=1", run); end
   endtask

   task automatic test_halt();
      apply_reset();
      pc = 64'h0;
      @(negedge clk);
      pc = 64'h4;
      @(negedge clk);
      total++; if (done !== 1'b0 || status !== 2'd0) begin bad++; $display("FAIL halt_midrun got=done%0b/st%0d want=done0/st0", done, status); end
      pc = 64'h8; halted = 1'b1;
      @(negedge clk);
      total++; if (status !== 2'd1) begin bad++; $display("FAIL halt_status got=%0d want=1", status); end
      total++; if (done !== 1'b1 || run !== 1'b0) begin bad++; $display("FAIL halt_done got=done%0b/run%0b want=done1/run0", done, run); end
      total++; if (cycle_count !== 32'd3) begin bad++; $display("FAIL halt_cycles got=%0d want=3", cycle_count); end
      total++; if (trace_count !== 5'd3) begin bad++; $display("FAIL halt_trace_count got=%0d want=3", trace_count); end
      for (int i = 0; i < 4; i++) begin
         logic [63:0] exp_pc;
         exp_pc = (i < 3) ? 64'(4 * i) : 64'd0;
         rd_idx = 4'(i); #1;
         total++; if (rd_pc !== exp_pc) begin bad++; $display("FAIL halt_trace_idx%0d got=%h want=%h", i, rd_pc, exp_pc); end
      end
      halted = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pc = 64'h1000 + 64'(i);
         @(negedge clk);
      end
      total++; if (done !== 1'b1 || status !== 2'd1 || cycle_count !== 32'd3 || trace_count !== 5'd3) begin
         bad++; $display("FAIL halt_frozen got=done%0b/st%0d/cyc%0d/tc%0d want=done1/st1/cyc3/tc3", done, status, cycle_count, trace_count);
      end
   endtask

   task automatic test_halt_first_edge();
      apply_reset();
      pc = 64'h20; halted = 1'b1;
      @(negedge clk);
      halted = 1'b0;
      rd_idx = 4'd0; #1;
      total++; if (status !== 2'd1 || cycle_count !== 32'd1) begin bad++; $display("FAIL halt_first got=st%0d/cyc%0d want=st1/cyc1", status, cycle_count); end
      total++; if (trace_count !== 5'd1 || rd_pc !== 64'h20) begin bad++; $display("FAIL halt_first_trace got=tc%0d/%h want=tc1/20", trace_count, rd_pc); end
   endtask

   task automatic test_timeout_wrap();
      apply_reset();
      for (int n = 0; n < 19; n++) begin
         pc = 64'h100 + 64'(4 * n);
         @(negedge clk);
      end
      total++; if (done !== 1'b0 || cycle_count !== 32'd19) begin bad++; $display("FAIL timeout_pre got=done%0b/cyc%0d want=done0/cyc19", done, cycle_count); end
      pc = 64'h100 + 64'(4 * 19);
      @(negedge clk);
      total++; if (status !== 2'd2 || done !== 1'b1) begin bad++; $display("FAIL timeout_status got=st%0d/done%0b want=st2/done1", status, done); end
      total++; if (cycle_count !== 32'd20) begin bad++; $display("FAIL timeout_cycles got=%0d want=20", cycle_count); end
      total++; if (trace_count !== 5'd16) begin bad++; $display("FAIL wrap_trace_count got=%0d want=16", trace_count); end
      rd_idx = 4'd0; #1;
      total++; if (rd_pc !== 64'h110) begin bad++; $display("FAIL wrap_idx0 got=%h want=110", rd_pc); end
      rd_idx = 4'd1; #1;
      total++; if (rd_pc !== 64'h114) begin bad++; $display("FAIL wrap_idx1 got=%h want=114", rd_pc); end
      rd_idx = 4'd15; #1;
      total++; if (rd_pc !== 64'h14C) begin bad++; $display("FAIL wrap_idx15 got=%h want=14c", rd_pc); end
      for (int n = 0; n < 10; n++) begin
         pc = 64'h2000 + 64'(8 * n); halted = n[0];
         @(negedge clk);
         total++; if (done !== 1'b1 || status !== 2'd2 || cycle_count !== 32'd20) begin
            bad++; $display("FAIL timeout_sticky%0d got=done%0b/st%0d/cyc%0d want=done1/st2/cyc20", n, done, status, cycle_count);
         end
      end
      halted = 1'b0;
      rd_idx = 4'd0; #1;
      total++; if (rd_pc !== 64'h110 || trace_count !== 5'd16) begin bad++; $display("FAIL trace_frozen got=%h/tc%0d want=110/tc16", rd_pc, trace_count); end
   endtask

   task automatic test_loop();
      apply_reset();
      for (int n = 1; n <= 4; n++) begin
         pc = 64'h40;
         @(negedge clk);
      end
      total++; if (done !== 1'b0 || cycle_count !== 32'd4) begin bad++; $display("FAIL loop_pre got=done%0b/cyc%0d want=done0/cyc4", done, cycle_count); end
      @(negedge clk);
`ifdef CPU_RUN_MONITOR_LOOP_DET_EN
      total++; if (status !== 2'd3 || done !== 1'b1 || cycle_count !== 32'd5) begin
         bad++; $display("FAIL loop_end got=st%0d/done%0b/cyc%0d want=st3/done1/cyc5", status, done, cycle_count);
      end
`else
      total++; if (done !== 1'b0) begin bad++; $display("FAIL loop_no_det got=done%0b want=done0", done); end
      for (int n = 6; n <= 20; n++) begin
         @(negedge clk);
      end
      total++; if (status !== 2'd2 || done !== 1'b1 || cycle_count !== 32'd20) begin
         bad++; $display("FAIL loop_timeout got=st%0d/done%0b/cyc%0d want=st2/done1/cyc20", status, done, cycle_count);
      end
`endif
      rd_idx = 4'd0; #1;
      total++; if (trace_count !== 5'd1 || rd_pc !== 64'h40) begin bad++; $display("FAIL loop_trace got=tc%0d/%h want=tc1/40", trace_count, rd_pc); end
      rd_idx = 4'd1; #1;
      total++; if (rd_pc !== 64'd0) begin bad++; $display("FAIL loop_trace_idx1 got=%h want=0", rd_pc); end
   endtask

   task automatic test_halt_timeout_same_edge();
      apply_reset();
      for (int n = 1; n <= 20; n++) begin
         pc = 64'(8 * n); halted = (n == 20);
         @(negedge clk);
      end
      halted = 1'b0;
      total++; if (status !== 2'd1 || cycle_count !== 32'd20) begin bad++; $display("FAIL halt_vs_timeout got=st%0d/cyc%0d want=st1/cyc20", status, cycle_count); end
   endtask

   task automatic test_midrun_reset();
      apply_reset();
      for (int n = 0; n < 7; n++) begin
         pc = 64'h300 + 64'(4 * n);
         @(negedge clk);
      end
      total++; if (cycle_count !== 32'd7 || trace_count !== 5'd7) begin bad++; $display("FAIL midrun_pre got=cyc%0d/tc%0d want=cyc7/tc7", cycle_count, trace_count); end
      #2 rst = 1'b1;
      #1;
      total++; if (cpu_reset !== 1'b1 || run !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL midrun_async_ctrl got=cr%0b/run%0b/done%0b want=cr1/run0/done0", cpu_reset, run, done);
      end
      total++; if (cycle_count !== 32'd0 || trace_count !== 5'd0 || status !== 2'd0) begin
         bad++; $display("FAIL midrun_async_obs got=cyc%0d/tc%0d/st%0d want=0/0/0", cycle_count, trace_count, status);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      total++; if (cpu_reset !== 1'b1 || run !== 1'b0) begin bad++; $display("FAIL midrun_hold1 got=cr%0b/run%0b want=cr1/run0", cpu_reset, run); end
      @(posedge clk); #1;
      total++; if (cpu_reset !== 1'b0 || run !== 1'b1 || cycle_count !== 32'd0) begin
         bad++; $display("FAIL midrun_hold2 got=cr%0b/run%0b/cyc%0d want=cr0/run1/cyc0", cpu_reset, run, cycle_count);
      end
   endtask

   initial begin
      rst = 1'b1; pc = '0; halted = 1'b0; rd_idx = '0;
      test_reset();
      test_halt();
      test_halt_first_edge();
      test_timeout_wrap();
      test_loop();
      test_halt_timeout_same_edge();
      test_midrun_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
